// File: rtl/frame_receiver_if.sv
// Byte stream from the UART receiver into the frame parser.
// master = UART side (drives the strobe), slave = parser.
interface frame_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/frame_receiver.sv
// Parses 13-byte command frames (52 0D 01 D0..D7 C 9A) from a UART byte stream,
// latching the payload only for fully valid frames and flagging every rejection.
module frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_receiver_if.slave  rx_if,
    input  logic [2:0]       sel_i,
    output logic [63:0]      data_out_o,
    output logic [7:0]       preview_data_o,
    output logic             frame_valid_o,
    output logic             frame_err_o,
    output logic [2:0]       err_code_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic             busy_o
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] HDR_BYTE  = 8'h52;
    localparam logic [7:0] LEN_BYTE  = 8'h0D;
    localparam logic [7:0] FUNC_BYTE = 8'h01;
    localparam logic [7:0] TAIL_BYTE = 8'h9A;
    localparam logic [7:0] SUM_OK    = 8'hFF;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_FUNC    = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TAIL    = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_FUNC,
        S_DATA,
        S_CSUM,
        S_TAIL
    } state_t;

    state_t            state_q;
    logic [7:0]        stage_q [8];
    logic [2:0]        idx_q;
    logic [7:0]        sum_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [63:0]       data_out_q;
    logic [7:0]        preview_q;
    logic              frame_valid_q;
    logic              frame_err_q;
    logic [2:0]        err_code_q;
    logic [CNT_W-1:0]  good_cnt_q;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        sum_d;
    logic [63:0]       stage_flat;
    logic [7:0]        out_bytes [8];

    assign rx_byte  = rx_if.rx_data;
    assign rx_valid = rx_if.rx_valid;
    assign sum_d    = sum_q + rx_byte;

    // Byte 0 sits in the most significant lane of the 64-bit payload.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lanes
        assign stage_flat[63-8*gi -: 8] = stage_q[gi];
        assign out_bytes[gi]            = data_out_q[63-8*gi -: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            to_cnt_q      <= '0;
            data_out_q    <= '0;
            preview_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
            good_cnt_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            preview_q     <= out_bytes[sel_i];

            if (rx_valid) begin
                to_cnt_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (rx_byte == HDR_BYTE) begin
                            state_q <= S_LEN;
                            sum_q   <= HDR_BYTE;
                        end
                    end
                    S_LEN: begin
                        if (rx_byte == LEN_BYTE) begin
                            state_q <= S_FUNC;
                            sum_q   <= sum_d;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            // A stray header restarts parsing instead of being lost.
                            state_q     <= (rx_byte == HDR_BYTE) ? S_LEN : S_IDLE;
                            sum_q       <= HDR_BYTE;
                        end
                    end
                    S_FUNC: begin
                        if (rx_byte == FUNC_BYTE) begin
                            state_q <= S_DATA;
                            sum_q   <= sum_d;
                            idx_q   <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_FUNC;
                            state_q     <= (rx_byte == HDR_BYTE) ? S_LEN : S_IDLE;
                            sum_q       <= HDR_BYTE;
                        end
                    end
                    S_DATA: begin
                        stage_q[idx_q] <= rx_byte;
                        sum_q          <= sum_d;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        sum_q   <= sum_d;
                        state_q <= S_TAIL;
                    end
                    S_TAIL: begin
                        state_q <= S_IDLE;
                        if (rx_byte != TAIL_BYTE) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_TAIL;
                        end else if (sum_d != SUM_OK) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                        end else begin
                            data_out_q    <= stage_flat;
                            frame_valid_q <= 1'b1;
                            good_cnt_q    <= good_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q == S_IDLE) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_q     <= S_IDLE;
                to_cnt_q    <= '0;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign data_out_o     = data_out_q;
    assign preview_data_o = preview_q;
    assign frame_valid_o  = frame_valid_q;
    assign frame_err_o    = frame_err_q;
    assign err_code_o     = err_code_q;
    assign good_cnt_o     = good_cnt_q;
    assign busy_o         = (state_q != S_IDLE);
endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: directed scenarios then random frames, every cycle
// compared against a byte-buffer reference model of the frame rules.
module tb_frame_receiver;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    sel = 3'd0;
    logic [63:0]   data_out;
    logic [7:0]    preview_data;
    logic          frame_valid;
    logic          frame_err;
    logic [2:0]    err_code;
    logic [CW-1:0] good_cnt;
    logic          busy;

    frame_receiver_if rx_if ();

    frame_receiver #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_if          (rx_if),
        .sel_i          (sel),
        .data_out_o     (data_out),
        .preview_data_o (preview_data),
        .frame_valid_o  (frame_valid),
        .frame_err_o    (frame_err),
        .err_code_o     (err_code),
        .good_cnt_o     (good_cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference model state: bytes of the frame collected so far, idle gap, outputs.
    logic [7:0]    fbuf [$];
    int            idle_cnt = 0;
    logic [63:0]   m_data = '0;
    logic [CW-1:0] m_cnt = '0;
    logic [2:0]    m_code = '0;
    logic          m_fv = 1'b0;
    logic          m_fe = 1'b0;
    logic [7:0]    m_prev = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_err(input logic [2:0] code, input logic [7:0] b, input logic resync);
        m_fe   = 1'b1;
        m_code = code;
        fbuf.delete();
        if (resync && b == 8'h52) fbuf.push_back(b);
        n_txn++;
        $display("txn %0d: frame rejected, code %0d", n_txn, code);
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic [63:0] sh;
        logic [7:0]  s;
        int          n;
        sh     = m_data >> (8 * (7 - int'(sel)));
        m_prev = sh[7:0];
        m_fv   = 1'b0;
        m_fe   = 1'b0;
        if (!rst_n) begin
            fbuf.delete();
            idle_cnt = 0;
            m_data = '0; m_cnt = '0; m_code = '0; m_prev = '0;
        end else if (v) begin
            idle_cnt = 0;
            if (fbuf.size() == 0) begin
                if (b == 8'h52) fbuf.push_back(b);
            end else begin
                fbuf.push_back(b);
                n = fbuf.size();
                if (n == 2 && b != 8'h0D) model_err(3'd1, b, 1'b1);
                else if (n == 3 && b != 8'h01) model_err(3'd2, b, 1'b1);
                else if (n == 13) begin
                    s = 8'h00;
                    foreach (fbuf[i]) s = s + fbuf[i];
                    if (b != 8'h9A) model_err(3'd4, b, 1'b0);
                    else if (s != 8'hFF) model_err(3'd3, b, 1'b0);
                    else begin
                        for (int i = 0; i < 8; i++) m_data[63-8*i -: 8] = fbuf[3+i];
                        m_cnt = m_cnt + 1'b1;
                        m_fv  = 1'b1;
                        fbuf.delete();
                        n_txn++;
                        $display("txn %0d: good frame, payload %h", n_txn, m_data);
                    end
                end
            end
        end else if (fbuf.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TO) model_err(3'd5, 8'h00, 1'b0);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        rx_if.rx_valid = v;
        rx_if.rx_data  = v ? b : 8'($urandom);
        model_step(v, b);
        @(posedge clk);
        #1;
        check_eq("frame_valid", 64'(frame_valid), 64'(m_fv));
        check_eq("frame_err", 64'(frame_err), 64'(m_fe));
        check_eq("err_code", 64'(err_code), 64'(m_code));
        check_eq("data_out", data_out, m_data);
        check_eq("good_cnt", 64'(good_cnt), 64'(m_cnt));
        check_eq("busy", 64'(busy), 64'(fbuf.size() != 0));
        check_eq("preview", 64'(preview_data), 64'(m_prev));
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Sends header/len/func, payload, checksum (correct one xor cx) and tail.
    task automatic send_frame(input logic [63:0] pl, input logic [7:0] lenb, input logic [7:0] funcb,
                              input logic [7:0] cx, input logic [7:0] tail, input int max_gap);
        logic [7:0] bytes [13];
        logic [7:0] s;
        bytes[0] = 8'h52; bytes[1] = lenb; bytes[2] = funcb;
        for (int i = 0; i < 8; i++) bytes[3+i] = pl[63-8*i -: 8];
        s = 8'h52 + 8'h0D + 8'h01 + 8'h9A;
        for (int i = 0; i < 8; i++) s = s + bytes[3+i];
        bytes[11] = (~s) ^ cx;
        bytes[12] = tail;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, bytes[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // All-zero payload.
        send_frame(64'h0, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        idle(2);
        // Counting payload, then preview of byte 3.
        send_frame(64'h0102030405060708, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        sel = 3'd3;
        idle(3);
        // Bad checksum, then bad tail.
        send_frame(64'h0102030405060708, 8'h0D, 8'h01, 8'h01, 8'h9A, 0);
        idle(2);
        send_frame(64'h0102030405060708, 8'h0D, 8'h01, 8'h00, 8'h9B, 0);
        idle(2);
        // Doubled header resyncs.
        step(1'b1, 8'h52);
        send_frame(64'h0, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        idle(2);
        // Timeout inside a frame, then a good frame.
        step(1'b1, 8'h52); step(1'b1, 8'h0D); step(1'b1, 8'h01); step(1'b1, 8'hAA);
        idle(TO + 2);
        send_frame(64'h1122334455667788, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        // Reset mid-frame after five data bytes.
        step(1'b1, 8'h52); step(1'b1, 8'h0D); step(1'b1, 8'h01);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1));
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send_frame(64'hCAFE_F00D_5252_9A9A, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        idle(1);
        // Back-to-back frames with no gap.
        send_frame(64'hDEAD_BEEF_0000_0001, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);
        send_frame(64'hDEAD_BEEF_0000_0002, 8'h0D, 8'h01, 8'h00, 8'h9A, 0);

        for (int f = 0; f < 80; f++) begin
            logic [63:0] pl;
            logic [7:0]  lenb, funcb, cx, tail;
            int          kind;
            pl    = {32'($urandom), 32'($urandom)};
            lenb  = 8'h0D; funcb = 8'h01; cx = 8'h00; tail = 8'h9A;
            kind  = $urandom_range(0, 11);
            sel   = 3'($urandom);
            if ($urandom_range(0, 5) == 0) step(1'b1, 8'($urandom));
            case (kind)
                0: lenb  = ($urandom_range(0, 1) == 0) ? 8'h52 : (8'h0D ^ 8'($urandom_range(1, 255)));
                1: funcb = ($urandom_range(0, 1) == 0) ? 8'h52 : (8'h01 ^ 8'($urandom_range(1, 255)));
                2: cx    = 8'($urandom_range(1, 255));
                3: tail  = 8'h9A ^ 8'($urandom_range(1, 255));
                default: ;
            endcase
            if (kind == 4) begin
                step(1'b1, 8'h52); step(1'b1, 8'h0D);
                idle(TO + $urandom_range(0, 3));
            end else if (kind == 5 && f % 3 == 0) begin
                step(1'b1, 8'h52); step(1'b1, 8'h0D); step(1'b1, 8'h01);
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end else begin
                send_frame(pl, lenb, funcb, cx, tail, (kind == 6) ? 3 : 0);
            end
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
Receive-side counterpart of the 13-byte command frame built by the sender controller. Consumes the byte stream from the UART receiver (one byte per rx_valid pulse). Parses and validates header, length, function code, checksum and tail. Latches the 8 payload bytes into a holding register only when the whole frame is good, and exposes one selectable byte for display.

Parameters:
TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes inside a frame before abort (min 2)
CNT_W, 16, width of good-frame counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
rx_data  input  8  received byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
sel  input  3  payload byte index for preview_data
data_out  output  64  last good payload; byte0 in [63:56] … byte7 in [7:0]
preview_data  output  8  registered copy of data_out byte[sel]
frame_valid  output  1  one-cycle pulse: good frame latched
frame_err  output  1  one-cycle pulse: frame rejected
err_code  output  3  cause of last rejection, held until the next error
good_cnt  output  CNT_W  count of good frames, wraps
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, data_out=0, preview_data=0, frame_valid=0, frame_err=0, err_code=0, good_cnt=0.
  - Staging registers, running sum and timeout counter cleared.
  - A partial frame in progress is discarded silently; no error is flagged.
- Frame format, in order: 0x52, 0x0D, 0x01, D0..D7, C, 0x9A.
  - Good checksum: (0x52+0x0D+0x01+D0+…+D7+C+0x9A) mod 256 == 0xFF, i.e. C = ~(sum of all other bytes).
- Only cycles with rx_valid=1 advance the FSM. Bytes are processed in the cycle they arrive.
- States and transitions:
  - IDLE: byte==0x52 → LEN, running sum=0x52. Any other byte is ignored with no error.
  - LEN: byte==0x0D → FUNC. Otherwise error code 1.
  - FUNC: byte==0x01 → DATA, idx=0. Otherwise error code 2.
  - DATA: store byte in stage[idx] and add it to the sum. idx==7 → CSUM, else idx+1. Any value is accepted, including 0x52.
  - CSUM: store C and add it to the sum → TAIL.
  - TAIL:
    - byte==0x9A and final sum (incl. 0x9A) ==0xFF → good frame, → IDLE.
    - byte==0x9A and sum !=0xFF → error code 3.
    - byte!=0x9A → error code 4 (takes priority over code 3).
- Error handling:
  - frame_err=1 for one cycle and err_code is updated in the cycle after the offending byte.
  - data_out is unchanged and the staging contents are discarded.
  - Next state is IDLE, except in LEN or FUNC when the offending byte ==0x52: that byte is taken as a new header (→ LEN, sum=0x52).
- Good frame, in the cycle after the tail byte:
  - data_out ← staged bytes.
  - frame_valid=1 for one cycle.
  - good_cnt+1, wrapping at 2^CNT_W.
- Timeout:
  - Counter clears on every rx_valid and is held at 0 in IDLE.
  - Outside IDLE it increments each cycle without rx_valid.
  - When the counter == TIMEOUT_CYCLES-1 and rx_valid=0: → IDLE, frame_err pulse, err_code=5.
  - If rx_valid arrives in that same cycle, the byte wins and there is no timeout.
- preview_data:
  - Registered every cycle as data_out byte[sel], so it has one cycle of latency after a sel change.
  - It reflects the new data_out one cycle after frame_valid.
- Other rules:
  - frame_valid and frame_err are never asserted in the same cycle.
  - Back-to-back frames are supported: a 0x52 arriving one cycle after the tail byte is accepted in IDLE.
  - All sums are 8-bit and wrap mod 256.

Test Plan:
1. Send 52 0D 01 00×8 05 9A → frame_valid pulse; data_out=0; good_cnt=1; frame_err never asserted.
2. Send 52 0D 01 01 02 03 04 05 06 07 08 E1 9A, then sel=3 → data_out=0x0102030405060708; preview_data=0x04 two cycles after the sel change.
3. Repeat scenario 2 with checksum byte E0 → frame_err pulse; err_code=3; data_out keeps its previous value; good_cnt unchanged. Repeat with tail 9B → err_code=4.
4. Send 52 52 0D 01 00×8 05 9A → frame_err with err_code=1 on the second 0x52; resync; then frame_valid and data_out=0.
5. With TIMEOUT_CYCLES=16: send 52 0D 01 AA, then stay idle for 16 cycles → frame_err; err_code=5; busy=0; a following full good frame is accepted.
6. Assert rst_n=0 after the 5th data byte, release it, then send a good frame → no frame_err at any point; frame_valid on the new frame; good_cnt=1.
